// File: rtl/pulse_maker_mc.sv
// pulse_maker_mc: multi-channel falling-edge pulse generator with programmable delay/width and status
// Ports:
//   clk      - single clock, all state on posedge
//   reset    - asynchronous, active-high
//   in       - per-channel trigger inputs (falling edge)
//   dly, wid - shared delay / pulse width, captured at trigger (wid 0 acts as 1)
//   clr_ovr  - synchronous clear of all overrun flags
//   out_n    - registered active-low pulses
//   busy     - channel sequencing (not IDLE)
//   done     - one-cycle strobe when a pulse completes
//   ovr      - sticky flag, set when a trigger is ignored
// Option: define PULSE_MAKER_MC_SYNC_EN to put a 2-flop synchroniser on every in bit.
module pulse_maker_mc #(
    parameter int CHANNELS = 4,
    parameter int DLY_W    = 4,
    parameter int WID_W    = 4,
    parameter int RETRIG   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    input  logic [DLY_W-1:0]    dly,
    input  logic [WID_W-1:0]    wid,
    input  logic                clr_ovr,
    output logic [CHANNELS-1:0] out_n,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done,
    output logic [CHANNELS-1:0] ovr
);
    localparam int CW = (DLY_W > WID_W) ? DLY_W : WID_W;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

    logic [CHANNELS-1:0] w_in_s, r_in_q, w_trig;
    logic [CW-1:0]       w_dly, w_wid;

    // Sample history resets as if the line were low, so a line already low
    // when reset releases must first be seen high before it can fire.
`ifdef PULSE_MAKER_MC_SYNC_EN
    logic [CHANNELS-1:0] r_s1, r_s2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in;
            r_s2 <= r_s1;
        end
    end
    assign w_in_s = r_s2;
`else
    assign w_in_s = in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_in_q <= '0;
        else       r_in_q <= w_in_s;
    end

    assign w_trig = r_in_q & ~w_in_s;
    assign w_dly  = CW'(dly);
    assign w_wid  = (wid == '0) ? ONE : CW'(wid);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t        r_state, w_next;
        logic [CW-1:0] r_cnt, w_cnt, r_wid, w_wid_n;
        logic          r_out_n, r_done, r_ovr;
        logic          w_load, w_ign, w_out_n, w_done, w_ovr;

        // A trigger starts a sequence from IDLE, or restarts one when retriggering is allowed.
        assign w_load = w_trig[c] && (r_state == IDLE || RETRIG != 0);
        assign w_ign  = w_trig[c] && r_state != IDLE && RETRIG == 0;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_wid   <= ONE;
                r_out_n <= 1'b1;
                r_done  <= 1'b0;
                r_ovr   <= 1'b0;
            end else begin
                r_state <= w_next;
                r_cnt   <= w_cnt;
                r_wid   <= w_wid_n;
                r_out_n <= w_out_n;
                r_done  <= w_done;
                r_ovr   <= w_ovr;
            end
        end

        // Width is captured at trigger so a later change of wid cannot stretch a pending pulse.
        always_comb begin
            w_next  = r_state;
            w_cnt   = r_cnt;
            w_wid_n = r_wid;
            if (w_load) begin
                w_next  = (dly == '0) ? PULSE : DELAY;
                w_cnt   = (dly == '0) ? w_wid : w_dly;
                w_wid_n = w_wid;
            end else if (r_state == DELAY) begin
                w_next = (r_cnt == ONE) ? PULSE : DELAY;
                w_cnt  = (r_cnt == ONE) ? r_wid : r_cnt - ONE;
            end else if (r_state == PULSE) begin
                w_next = (r_cnt == ONE) ? IDLE : PULSE;
                w_cnt  = r_cnt - ONE;
            end
        end

        // A restart on the last pulse cycle suppresses done; an ignored trigger beats clr_ovr.
        always_comb begin
            w_out_n = (w_next != PULSE);
            w_done  = (r_state == PULSE) && (r_cnt == ONE) && !w_load;
            w_ovr   = w_ign || (r_ovr && !clr_ovr);
        end

        assign out_n[c] = r_out_n;
        assign busy[c]  = (r_state != IDLE);
        assign done[c]  = r_done;
        assign ovr[c]   = r_ovr;
    end
endmodule

// File: tb/tb_pulse_maker_mc.sv
// tb_pulse_maker_mc: directed table-driven bench for pulse_maker_mc (RETRIG=0 and RETRIG=1 instances)
module tb_pulse_maker_mc;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] tin = 4'h0;
    logic [3:0] dly = 4'h0;
    logic [3:0] wid = 4'h0;
    logic       clr_ovr = 1'b0;
    logic [3:0] out_n0, busy0, done0, ovr0;
    logic [3:0] out_n1, busy1, done1, ovr1;
    int         total = 0;
    int         passed = 0;

    typedef struct {
        logic [3:0] in;
        logic [3:0] dly;
        logic [3:0] wid;
        logic       clr;
        logic [3:0] on;
        logic [3:0] bz;
        logic [3:0] dn;
        logic [3:0] ov;
    } vec_t;
    vec_t tv[$];

    pulse_maker_mc #(.CHANNELS(4), .DLY_W(4), .WID_W(4), .RETRIG(0)) u0 (
        .clk(clk), .reset(reset), .in(tin), .dly(dly), .wid(wid), .clr_ovr(clr_ovr),
        .out_n(out_n0), .busy(busy0), .done(done0), .ovr(ovr0)
    );

    pulse_maker_mc #(.CHANNELS(4), .DLY_W(4), .WID_W(4), .RETRIG(1)) u1 (
        .clk(clk), .reset(reset), .in(tin), .dly(dly), .wid(wid), .clr_ovr(clr_ovr),
        .out_n(out_n1), .busy(busy1), .done(done1), .ovr(ovr1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %0h required %0h", n, a, e);
        else passed++;
    endtask

    task automatic step(input logic [3:0] i, input logic [3:0] d, input logic [3:0] w, input logic c);
        @(negedge clk);
        tin = i; dly = d; wid = w; clr_ovr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] i, input logic [3:0] d, input logic [3:0] w, input logic c,
                       input logic [3:0] on, input logic [3:0] bz, input logic [3:0] dn, input logic [3:0] ov);
        vec_t v;
        v.in = i; v.dly = d; v.wid = w; v.clr = c; v.on = on; v.bz = bz; v.dn = dn; v.ov = ov;
        tv.push_back(v);
    endtask

    initial begin
        int ndone;
        logic [3:0] sin;
        // ch0 dly=2 wid=3; wid changes after trigger must not matter
        add(4'hF,2,3,0, 4'hF,4'h0,4'h0,4'h0);
        add(4'hE,2,3,0, 4'hF,4'h1,4'h0,4'h0);
        add(4'hE,5,7,0, 4'hF,4'h1,4'h0,4'h0);
        add(4'hE,5,7,0, 4'hE,4'h1,4'h0,4'h0);
        add(4'hE,5,7,0, 4'hE,4'h1,4'h0,4'h0);
        add(4'hE,5,7,0, 4'hE,4'h1,4'h0,4'h0);
        add(4'hE,5,7,0, 4'hF,4'h0,4'h1,4'h0);
        add(4'hF,5,7,0, 4'hF,4'h0,4'h0,4'h0);
        // ch1 dly=0 wid=0: one-cycle pulse at the trigger edge
        add(4'hD,0,0,0, 4'hD,4'h2,4'h0,4'h0);
        add(4'hD,0,0,0, 4'hF,4'h0,4'h2,4'h0);
        add(4'hF,0,0,0, 4'hF,4'h0,4'h0,4'h0);
        // all channels together, dly=1 wid=1
        add(4'h0,1,1,0, 4'hF,4'hF,4'h0,4'h0);
        add(4'h0,1,1,0, 4'h0,4'hF,4'h0,4'h0);
        add(4'h0,1,1,0, 4'hF,4'h0,4'hF,4'h0);
        add(4'hF,1,1,0, 4'hF,4'h0,4'h0,4'h0);
        // ch2 dly=3 wid=4, ignored trigger at T+4, then clr_ovr racing a new ignored trigger
        add(4'hB,3,4,0, 4'hF,4'h4,4'h0,4'h0);
        add(4'hF,3,4,0, 4'hF,4'h4,4'h0,4'h0);
        add(4'hF,3,4,0, 4'hF,4'h4,4'h0,4'h0);
        add(4'hF,3,4,0, 4'hB,4'h4,4'h0,4'h0);
        add(4'hB,3,4,0, 4'hB,4'h4,4'h0,4'h4);
        add(4'hB,3,4,0, 4'hB,4'h4,4'h0,4'h4);
        add(4'hB,3,4,0, 4'hB,4'h4,4'h0,4'h4);
        add(4'hB,3,4,0, 4'hF,4'h0,4'h4,4'h4);
        add(4'hF,3,4,0, 4'hF,4'h0,4'h0,4'h4);
        add(4'hB,3,4,0, 4'hF,4'h4,4'h0,4'h4);
        add(4'hF,3,4,0, 4'hF,4'h4,4'h0,4'h4);
        add(4'hB,3,4,1, 4'hF,4'h4,4'h0,4'h4);
        add(4'hF,3,4,1, 4'hB,4'h4,4'h0,4'h0);
        add(4'hF,3,4,0, 4'hB,4'h4,4'h0,4'h0);
        add(4'hF,3,4,0, 4'hB,4'h4,4'h0,4'h0);
        add(4'hF,3,4,0, 4'hB,4'h4,4'h0,4'h0);
        add(4'hF,3,4,0, 4'hF,4'h0,4'h4,4'h0);
        // ch3 dly=0 wid=2, trigger on the final pulse cycle is ignored, done still fires
        add(4'h7,0,2,0, 4'h7,4'h8,4'h0,4'h0);
        add(4'hF,0,2,0, 4'h7,4'h8,4'h0,4'h0);
        add(4'h7,0,2,0, 4'hF,4'h0,4'h8,4'h8);
        add(4'hF,0,2,0, 4'hF,4'h0,4'h0,4'h8);
        add(4'hF,0,2,1, 4'hF,4'h0,4'h0,4'h0);
        add(4'hF,0,2,0, 4'hF,4'h0,4'h0,4'h0);

        // reset with all inputs low, then 10 cycles with no activity
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_n", out_n0, 4'hF);
        chk("rst_busy", busy0, 4'h0);
        chk("rst_done", done0, 4'h0);
        chk("rst_ovr", ovr0, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(4'h0, 4'd1, 4'd1, 1'b0);
            chk("low_at_release_out_n", out_n0, 4'hF);
            chk("low_at_release_busy", busy0, 4'h0);
            chk("low_at_release_ovr", ovr0, 4'h0);
            chk("low_at_release_out_n_rt", out_n1, 4'hF);
        end

        for (int k = 0; k < tv.size(); k++) begin
            step(tv[k].in, tv[k].dly, tv[k].wid, tv[k].clr);
            chk($sformatf("vec%0d_out_n", k), out_n0, tv[k].on);
            chk($sformatf("vec%0d_busy", k), busy0, tv[k].bz);
            chk($sformatf("vec%0d_done", k), done0, tv[k].dn);
            chk($sformatf("vec%0d_ovr", k), ovr0, tv[k].ov);
        end
        repeat (4) step(4'hF, 4'd2, 4'd5, 1'b0);

        // RETRIG=1 ch0 dly=2 wid=5, retrigger at T+3 during PULSE
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            sin = (i == 1 || i == 2) ? 4'hF : 4'hE;
            step(sin, 4'd2, 4'd5, 1'b0);
            chk($sformatf("retrig_out_n_t%0d", i), out_n1[0], !((i == 2) || (i >= 5 && i <= 9)));
            chk($sformatf("retrig_done_t%0d", i), done1[0], (i == 10));
            ndone += int'(done1[0]);
        end
        chk("retrig_done_count", ndone, 1);
        chk("retrig_no_ovr", ovr1, 4'h0);
        chk("noretrig_ovr", ovr0, 4'h1);
        step(4'hF, 4'd1, 4'd8, 1'b1);
        chk("clr_after_retrig", ovr0, 4'h0);

        // asynchronous reset in the middle of a dly=1 wid=8 pulse on ch1
        step(4'hD, 4'd1, 4'd8, 1'b0);
        step(4'hD, 4'd1, 4'd8, 1'b0);
        chk("pre_reset_out_n", out_n0, 4'hD);
        step(4'hD, 4'd1, 4'd8, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_out_n", out_n0, 4'hF);
        chk("async_reset_busy", busy0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            step(4'hD, 4'd1, 4'd8, 1'b0);
            chk("in_reset_done", done0, 4'h0);
        end
        reset = 1'b0;
        step(4'hD, 4'd1, 4'd8, 1'b0);
        chk("post_reset_no_done", done0, 4'h0);
        chk("post_reset_idle", busy0, 4'h0);
        step(4'hF, 4'd1, 4'd8, 1'b0);
        step(4'hD, 4'd1, 4'd8, 1'b0);
        chk("rearm_busy", busy0, 4'h2);
        for (int j = 1; j <= 9; j++) begin
            step(4'hD, 4'd1, 4'd8, 1'b0);
            chk($sformatf("rearm_out_n_t%0d", j), out_n0, (j <= 8) ? 4'hD : 4'hF);
            chk($sformatf("rearm_done_t%0d", j), done0, (j == 9) ? 4'h2 : 4'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
